// File: rtl/pi_servo.sv
// Lock-in PI servo: saturating error, shift gains, anti-windup,
// offset-binary DAC code with a one-cycle done strobe.
module pi_servo #(
  parameter int DATAWIDTH = 32,
  parameter int OUTWIDTH  = 16,
  parameter int KWIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 once,
  input  logic [DATAWIDTH-1:0] in,
  input  logic [DATAWIDTH-1:0] setpoint,
  input  logic [KWIDTH-1:0]    kp,
  input  logic [KWIDTH-1:0]    ki,
  input  logic                 enable,
  output logic                 done,
  output logic [OUTWIDTH-1:0]  out,
  output logic                 railed
);

  localparam int DW = DATAWIDTH;
  localparam int OW = OUTWIDTH;

  localparam logic [OW-1:0] MID = {1'b1, {(OW-1){1'b0}}};
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR,
    S_INT,
    S_OUT
  } state_t;

  state_t r_state;

  logic [DW-1:0] r_in;
  logic [DW-1:0] r_sp;
  logic signed [DW-1:0] r_err;
  logic signed [DW-1:0] r_integ;
  logic r_rail_hi;
  logic r_done;
  logic r_railed;
  logic [OW-1:0] r_out;

  function automatic logic [DW-1:0] sat(
    input logic [DW:0] x
  );
    if (x[DW] != x[DW-1])
      return x[DW] ? SMIN : SMAX;
    return x[DW-1:0];
  endfunction

  logic [DW:0] w_diff;
  logic signed [DW-1:0] w_istep;
  logic [DW:0] w_isum;
  logic signed [DW-1:0] w_p;
  logic [DW:0] w_usum;
  logic [DW-1:0] w_u;
  logic w_usat;
  logic [OW-1:0] w_code;
  logic w_err_pos;
  logic w_err_neg;
  logic w_hold;

  assign w_diff = {r_sp[DW-1], r_sp}
                - {r_in[DW-1], r_in};

  assign w_istep = r_err >>> ki;
  assign w_isum = {r_integ[DW-1], r_integ}
                + {w_istep[DW-1], w_istep};

  assign w_p = r_err >>> kp;
  assign w_usum = {w_p[DW-1], w_p}
                + {r_integ[DW-1], r_integ};
  assign w_u = sat(w_usum);
  assign w_usat = w_usum[DW] != w_usum[DW-1];

  // Top OW bits of u with the sign flipped give offset binary.
  assign w_code = {~w_u[DW-1], w_u[DW-2 -: OW-1]};

  assign w_err_neg = r_err[DW-1];
  assign w_err_pos = !r_err[DW-1] && (r_err != '0);
  assign w_hold = r_railed
               && ((r_rail_hi && w_err_pos)
               || (!r_rail_hi && w_err_neg));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_in      <= '0;
      r_sp      <= '0;
      r_err     <= '0;
      r_integ   <= '0;
      r_rail_hi <= 1'b0;
      r_done    <= 1'b0;
      r_railed  <= 1'b0;
      r_out     <= MID;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (once) begin
            r_in    <= in;
            r_sp    <= setpoint;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_err   <= sat(w_diff);
          r_state <= S_INT;
        end
        S_INT: begin
          if (!enable)
            r_integ <= '0;
          else if (!w_hold)
            r_integ <= sat(w_isum);
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (!enable) begin
            r_out    <= MID;
            r_railed <= 1'b0;
          end else begin
            r_out    <= w_code;
            r_railed <= w_usat
                     || (&w_code)
                     || (~|w_code);
            r_rail_hi <= ~w_u[DW-1];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign out    = r_out;
  assign railed = r_railed;

endmodule
